// File: rtl/afu_tx_ab_arb.sv
// afu_tx_ab_arb: merges two AFU TX AXI-stream sources (A, B) into a single
// stream toward the PF/VF mux. Arbitration happens per packet: a channel that
// wins a non-last first beat keeps the grant until its tlast beat is
// accepted, so packets are never interleaved. Ties in IDLE go to a 1-bit
// round-robin pointer that flips to the other channel after every packet.
// The merged stream goes through one registered output stage (latency 1) that
// can still move one beat per cycle while o_tready stays high.
module afu_tx_ab_arb #(
    parameter int DATA_W = 512,
    parameter int USER_W = 10
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  a_tvalid,
    output logic                  a_tready,
    input  logic [DATA_W-1:0]     a_tdata,
    input  logic [DATA_W/8-1:0]   a_tkeep,
    input  logic [USER_W-1:0]     a_tuser,
    input  logic                  a_tlast,

    input  logic                  b_tvalid,
    output logic                  b_tready,
    input  logic [DATA_W-1:0]     b_tdata,
    input  logic [DATA_W/8-1:0]   b_tkeep,
    input  logic [USER_W-1:0]     b_tuser,
    input  logic                  b_tlast,

    output logic                  o_tvalid,
    input  logic                  o_tready,
    output logic [DATA_W-1:0]     o_tdata,
    output logic [DATA_W/8-1:0]   o_tkeep,
    output logic [USER_W-1:0]     o_tuser,
    output logic                  o_tlast,
    output logic                  o_src,

    output logic [15:0]           pkt_cnt_a,
    output logic [15:0]           pkt_cnt_b
);

    localparam int KEEP_W = DATA_W / 8;

    // One stream beat; the payload passes through untouched.
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [KEEP_W-1:0] keep;
        logic [USER_W-1:0] user;
        logic              last;
    } beat_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_A = 2'd1,
        LOCK_B = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        prio_q,  prio_d;      // 0: A wins a tie, 1: B wins a tie
    logic        vld_q,   vld_d;       // output stage holds a beat
    beat_t       beat_q,  beat_d;
    logic        src_q,   src_d;
    logic [15:0] cnt_a_q, cnt_a_d;
    logic [15:0] cnt_b_q, cnt_b_d;

    beat_t a_beat, b_beat, sel_beat;
    logic  gnt_vld;                    // some channel owns the grant this cycle
    logic  gnt_b;                      // which one (0: A, 1: B)
    logic  sel_valid;
    logic  load;                       // output stage can take a new beat
    logic  accept;                     // granted beat is transferred this cycle

    assign a_beat = '{data: a_tdata, keep: a_tkeep, user: a_tuser, last: a_tlast};
    assign b_beat = '{data: b_tdata, keep: b_tkeep, user: b_tuser, last: b_tlast};

    // Grant selection: locked channel keeps the grant, otherwise pick among valids.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_b   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (a_tvalid && b_tvalid) begin
                    gnt_vld = 1'b1;
                    gnt_b   = prio_q;
                end else if (a_tvalid) begin
                    gnt_vld = 1'b1;
                    gnt_b   = 1'b0;
                end else if (b_tvalid) begin
                    gnt_vld = 1'b1;
                    gnt_b   = 1'b1;
                end
            end
            LOCK_A: begin
                gnt_vld = 1'b1;
                gnt_b   = 1'b0;
            end
            LOCK_B: begin
                gnt_vld = 1'b1;
                gnt_b   = 1'b1;
            end
            default: begin
                gnt_vld = 1'b0;
                gnt_b   = 1'b0;
            end
        endcase
    end

    // A full output stage frees up in the same cycle it is drained.
    assign load      = ~vld_q | o_tready;
    assign sel_beat  = gnt_b ? b_beat : a_beat;
    assign sel_valid = gnt_b ? b_tvalid : a_tvalid;

    // Reset gates the handshake so nothing is taken while rst is high.
    assign a_tready = ~rst & gnt_vld & ~gnt_b & load;
    assign b_tready = ~rst & gnt_vld &  gnt_b & load;
    assign accept   = ~rst & gnt_vld & sel_valid & load;

    // Next state for the lock FSM, round-robin pointer and packet counters.
    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        cnt_a_d = cnt_a_q;
        cnt_b_d = cnt_b_q;
        unique case (state_q)
            IDLE: begin
                // Single-beat packets never lock.
                if (accept && !sel_beat.last) begin
                    state_d = gnt_b ? LOCK_B : LOCK_A;
                end
            end
            LOCK_A, LOCK_B: begin
                if (accept && sel_beat.last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (accept && sel_beat.last) begin
            prio_d = ~gnt_b;
            if (gnt_b) begin
                cnt_b_d = cnt_b_q + 16'd1;
            end else begin
                cnt_a_d = cnt_a_q + 16'd1;
            end
        end
    end

    // Output stage: load on accept, drop valid when drained with nothing new.
    always_comb begin
        vld_d  = vld_q;
        beat_d = beat_q;
        src_d  = src_q;
        if (accept) begin
            vld_d  = 1'b1;
            beat_d = sel_beat;
            src_d  = gnt_b;
        end else if (o_tready) begin
            vld_d  = 1'b0;
        end
    end

    // Control state: cleared by reset, which also abandons any lock.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            vld_q   <= 1'b0;
            cnt_a_q <= '0;
            cnt_b_q <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            vld_q   <= vld_d;
            cnt_a_q <= cnt_a_d;
            cnt_b_q <= cnt_b_d;
        end
    end

    // Payload registers: meaningless while invalid, so no reset needed.
    always_ff @(posedge clk) begin
        beat_q <= beat_d;
        src_q  <= src_d;
    end

    assign o_tvalid  = vld_q & ~rst;
    assign o_tdata   = beat_q.data;
    assign o_tkeep   = beat_q.keep;
    assign o_tuser   = beat_q.user;
    assign o_tlast   = beat_q.last;
    assign o_src     = src_q;
    assign pkt_cnt_a = rst ? 16'd0 : cnt_a_q;
    assign pkt_cnt_b = rst ? 16'd0 : cnt_b_q;

endmodule

// File: tb/tb_afu_tx_ab_arb.sv
// Directed bench for afu_tx_ab_arb: expected beats are queued in the order
// the arbiter must emit them and compared as they leave the output port.
module tb_afu_tx_ab_arb;

    localparam int DATA_W = 512;
    localparam int USER_W = 10;
    localparam int KEEP_W = DATA_W / 8;

    logic              clk, rst;
    logic              a_tvalid, a_tready, a_tlast;
    logic [DATA_W-1:0] a_tdata;
    logic [KEEP_W-1:0] a_tkeep;
    logic [USER_W-1:0] a_tuser;
    logic              b_tvalid, b_tready, b_tlast;
    logic [DATA_W-1:0] b_tdata;
    logic [KEEP_W-1:0] b_tkeep;
    logic [USER_W-1:0] b_tuser;
    logic              o_tvalid, o_tready, o_tlast, o_src;
    logic [DATA_W-1:0] o_tdata;
    logic [KEEP_W-1:0] o_tkeep;
    logic [USER_W-1:0] o_tuser;
    logic [15:0]       pkt_cnt_a, pkt_cnt_b;

    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic [KEEP_W-1:0] k;
        logic [USER_W-1:0] u;
        logic              l;
        logic              s;
    } exp_t;

    exp_t sb[$];
    int   n_cmp, n_err;
    int   cyc;
    int   last_pop;
    bit   a_done;
    int   f0, f, l, fa, la, fb, lb, c;

    afu_tx_ab_arb #(.DATA_W(DATA_W), .USER_W(USER_W)) dut (
        .clk(clk), .rst(rst),
        .a_tvalid(a_tvalid), .a_tready(a_tready), .a_tdata(a_tdata),
        .a_tkeep(a_tkeep), .a_tuser(a_tuser), .a_tlast(a_tlast),
        .b_tvalid(b_tvalid), .b_tready(b_tready), .b_tdata(b_tdata),
        .b_tkeep(b_tkeep), .b_tuser(b_tuser), .b_tlast(b_tlast),
        .o_tvalid(o_tvalid), .o_tready(o_tready), .o_tdata(o_tdata),
        .o_tkeep(o_tkeep), .o_tuser(o_tuser), .o_tlast(o_tlast),
        .o_src(o_src), .pkt_cnt_a(pkt_cnt_a), .pkt_cnt_b(pkt_cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Payload encoding: every field derived from {tag, beat} so swaps show up.
    function automatic exp_t mk(input bit src, input int tag, input int beat, input bit last);
        exp_t        e;
        logic [31:0] w;
        w   = {tag[23:0], beat[7:0]};
        e.d = {16{w}};
        e.k = {2{~w}};
        e.u = w[13:4];
        e.l = last;
        e.s = src;
        return e;
    endfunction

    task automatic set_beat(input bit src, input int tag, input int beat, input bit last, input bit vld);
        exp_t e;
        e = mk(src, tag, beat, last);
        if (src) begin
            b_tvalid = vld; b_tdata = e.d; b_tkeep = e.k; b_tuser = e.u; b_tlast = e.l;
        end else begin
            a_tvalid = vld; a_tdata = e.d; a_tkeep = e.k; a_tuser = e.u; a_tlast = e.l;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the handshake cycle.
    task automatic wait_hs(input bit src, output int cy);
        bit got;
        int n;
        got = 1'b0;
        n   = 0;
        cy  = -1;
        while (!got && n < 200) begin
            @(negedge clk);
            got = src ? b_tready : a_tready;
            cy  = cyc;
            @(posedge clk);
            #1;
            n++;
        end
        chk("hs_timeout", got, 1);
    endtask

    task automatic send_pkt(input bit src, input int tag, input int nb, input int gap,
                            output int fc, output int lc);
        int cy;
        fc = -1;
        lc = -1;
        for (int b = 0; b < nb; b++) begin
            set_beat(src, tag, b, b == nb - 1, 1'b1);
            wait_hs(src, cy);
            if (b == 0) fc = cy;
            lc = cy;
            if (gap > 0 && b < nb - 1) begin
                set_beat(src, tag, b, 1'b0, 1'b0);
                repeat (gap) begin @(posedge clk); #1; end
            end
        end
        set_beat(src, tag, nb - 1, 1'b1, 1'b0);
    endtask

    task automatic push_pkt(input bit src, input int tag, input int nb);
        for (int b = 0; b < nb; b++) sb.push_back(mk(src, tag, b, b == nb - 1));
    endtask

    task automatic drain(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
    endtask

    // Output monitor: scoreboard pops, stall stability and stall back-pressure.
    task automatic monitor();
        bit   stall;
        exp_t hold, e;
        stall = 1'b0;
        hold  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall = 1'b0;
            end else begin
                if (stall) begin
                    chk("stall_vld",  o_tvalid, 1);
                    chk("stall_data", o_tdata, hold.d);
                    chk("stall_src",  o_src, hold.s);
                    chk("stall_last", o_tlast, hold.l);
                end
                if (o_tvalid && !o_tready) begin
                    chk("stall_rdy", {a_tready, b_tready}, 0);
                    stall  = 1'b1;
                    hold.d = o_tdata;
                    hold.s = o_src;
                    hold.l = o_tlast;
                end else begin
                    stall = 1'b0;
                end
                if (o_tvalid && o_tready) begin
                    if (sb.size() == 0) begin
                        chk("sb_underflow", o_tvalid, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("out_data", o_tdata, e.d);
                        chk("out_keep", o_tkeep, e.k);
                        chk("out_user", o_tuser, e.u);
                        chk("out_last", o_tlast, e.l);
                        chk("out_src",  o_src,   e.s);
                        last_pop = cyc;
                    end
                end
            end
        end
    endtask

    initial begin
        n_cmp = 0; n_err = 0; cyc = 0; last_pop = -1; a_done = 1'b0;
        rst = 1'b1; o_tready = 1'b1;
        a_tvalid = 1'b1; a_tdata = '0; a_tkeep = '0; a_tuser = '0; a_tlast = 1'b0;
        b_tvalid = 1'b1; b_tdata = '0; b_tkeep = '0; b_tuser = '0; b_tlast = 1'b0;
        fork monitor(); join_none

        // Reset state with both sources requesting
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_o_tvalid", o_tvalid, 0);
        chk("rst_a_tready", a_tready, 0);
        chk("rst_b_tready", b_tready, 0);
        chk("rst_cnt_a", pkt_cnt_a, 0);
        chk("rst_cnt_b", pkt_cnt_b, 0);
        @(posedge clk);
        #1;
        a_tvalid = 1'b0; b_tvalid = 1'b0; rst = 1'b0;

        // Single-beat packets on A only: one per cycle, latency 1
        for (int i = 0; i < 5; i++) push_pkt(0, 'h250 + i, 1);
        for (int i = 0; i < 5; i++) begin
            send_pkt(0, 'h250 + i, 1, 0, f, l);
            if (i == 0) f0 = f;
        end
        chk("t1_rate", l - f0, 4);
        drain(3);
        chk("t1_latency", last_pop - l, 1);
        chk("t1_cnt_a", pkt_cnt_a, 5);
        chk("t1_cnt_b", pkt_cnt_b, 0);
        chk("t1_sb_empty", sb.size(), 0);

        // Simultaneous 3-beat packets after reset: A whole, then B whole
        do_reset();
        push_pkt(0, 'h260, 3);
        push_pkt(1, 'h261, 3);
        fork
            send_pkt(0, 'h260, 3, 0, fa, la);
            send_pkt(1, 'h261, 3, 0, fb, lb);
        join
        drain(3);
        chk("t2_cnt_a", pkt_cnt_a, 1);
        chk("t2_cnt_b", pkt_cnt_b, 1);
        chk("t2_sb_empty", sb.size(), 0);
        // pointer is back on A: a fresh tie must go to A first
        push_pkt(0, 'h262, 1);
        push_pkt(1, 'h263, 1);
        fork
            send_pkt(0, 'h262, 1, 0, fa, la);
            send_pkt(1, 'h263, 1, 0, fb, lb);
        join
        drain(3);
        chk("t2_prio_cnt_a", pkt_cnt_a, 2);
        chk("t2_prio_cnt_b", pkt_cnt_b, 2);
        chk("t2_prio_sb_empty", sb.size(), 0);

        // 4-beat A packet under o_tready pattern 1,0,0,1
        push_pkt(0, 'h270, 4);
        fork
            send_pkt(0, 'h270, 4, 0, f, l);
            begin
                for (int i = 0; i < 40; i++) begin
                    o_tready = (i % 4 == 0) || (i % 4 == 3);
                    @(posedge clk);
                    #1;
                end
                o_tready = 1'b1;
            end
        join
        drain(3);
        chk("t3_sb_empty", sb.size(), 0);
        chk("t3_cnt_a", pkt_cnt_a, 3);

        // B requests while A is locked (A has gaps between beats)
        a_done = 1'b0;
        push_pkt(0, 'h280, 3);
        push_pkt(1, 'h281, 2);
        fork
            begin send_pkt(0, 'h280, 3, 2, fa, la); a_done = 1'b1; end
            begin
                repeat (2) @(posedge clk);
                #1;
                send_pkt(1, 'h281, 2, 0, fb, lb);
            end
            begin
                for (int n = 0; n < 300 && !a_done; n++) begin
                    @(negedge clk);
                    if (!a_done && b_tvalid) chk("t4_lock_b_tready", b_tready, 0);
                    @(posedge clk);
                end
            end
        join
        chk("t4_b_next_cycle", fb - la, 1);
        drain(3);
        chk("t4_sb_empty", sb.size(), 0);
        chk("t4_cnt_a", pkt_cnt_a, 4);
        chk("t4_cnt_b", pkt_cnt_b, 3);

        // Counter wrap on A; B count untouched
        do_reset();
        for (int i = 0; i < 2; i++) begin
            push_pkt(1, 'h290 + i, 1);
            send_pkt(1, 'h290 + i, 1, 0, f, l);
        end
        chk("t5_cnt_b_pre", pkt_cnt_b, 2);
        for (int i = 0; i < 65535; i++) begin
            push_pkt(0, i, 1);
            send_pkt(0, i, 1, 0, f, l);
        end
        chk("t5_cnt_a_max", pkt_cnt_a, 16'hFFFF);
        chk("t5_cnt_b_mid", pkt_cnt_b, 2);
        push_pkt(0, 'h29F, 1);
        send_pkt(0, 'h29F, 1, 0, f, l);
        chk("t5_cnt_a_wrap", pkt_cnt_a, 0);
        chk("t5_cnt_b_post", pkt_cnt_b, 2);
        drain(3);
        chk("t5_sb_empty", sb.size(), 0);

        // Reset after beat 2 of a 4-beat B packet (pointer currently on B)
        sb.push_back(mk(1, 'h300, 0, 1'b0));
        set_beat(1, 'h300, 0, 1'b0, 1'b1);
        wait_hs(1, c);
        set_beat(1, 'h300, 1, 1'b0, 1'b1);
        wait_hs(1, c);
        rst = 1'b1;
        set_beat(1, 'h300, 2, 1'b0, 1'b1);
        @(negedge clk);
        chk("t6_rst_o_tvalid", o_tvalid, 0);
        chk("t6_rst_a_tready", a_tready, 0);
        chk("t6_rst_b_tready", b_tready, 0);
        chk("t6_rst_cnt_a", pkt_cnt_a, 0);
        chk("t6_rst_cnt_b", pkt_cnt_b, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        set_beat(0, 'h301, 0, 1'b1, 1'b1);
        @(negedge clk);
        chk("t6_post_o_tvalid", o_tvalid, 0);
        chk("t6_post_cnt_a", pkt_cnt_a, 0);
        chk("t6_post_cnt_b", pkt_cnt_b, 0);
        chk("t6_post_a_tready", a_tready, 1);
        chk("t6_post_b_tready", b_tready, 0);
        sb.push_back(mk(0, 'h301, 0, 1'b1));
        sb.push_back(mk(1, 'h300, 2, 1'b0));
        sb.push_back(mk(1, 'h300, 3, 1'b1));
        @(posedge clk);
        #1;
        set_beat(0, 'h301, 0, 1'b1, 1'b0);
        wait_hs(1, c);
        set_beat(1, 'h300, 3, 1'b1, 1'b1);
        wait_hs(1, c);
        set_beat(1, 'h300, 3, 1'b1, 1'b0);
        drain(3);
        chk("t6_sb_empty", sb.size(), 0);
        chk("t6_cnt_a", pkt_cnt_a, 1);
        chk("t6_cnt_b", pkt_cnt_b, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
